// File: rtl/sub_bytes_scheduler_if.sv
// rtl/sub_bytes_scheduler_if.sv - request/response and shared S-box bundle for sub_bytes_scheduler
// master = requesters plus S-box unit side, slave = scheduler side.
interface sub_bytes_scheduler_if #(
    parameter int NUM_COLS = 4
);
    logic                    st_valid;
    logic                    st_ready;
    logic [32*NUM_COLS-1:0]  st_data;
    logic                    st_out_valid;
    logic [32*NUM_COLS-1:0]  st_out_data;
    logic                    key_valid;
    logic                    key_ready;
    logic [31:0]             key_word;
    logic                    key_out_valid;
    logic [31:0]             key_out_word;
    logic [31:0]             sb_in;
    logic [31:0]             sb_out;

    modport master (
        output st_valid, st_data, key_valid, key_word, sb_out,
        input  st_ready, st_out_valid, st_out_data,
        input  key_ready, key_out_valid, key_out_word, sb_in
    );

    modport slave (
        input  st_valid, st_data, key_valid, key_word, sb_out,
        output st_ready, st_out_valid, st_out_data,
        output key_ready, key_out_valid, key_out_word, sb_in
    );
endinterface

// File: rtl/sub_bytes_scheduler.sv
// rtl/sub_bytes_scheduler.sv - time-shares one column S-box between state rounds and key expansion
// State ops take one column per cycle; key ops take a single cycle; ties resolved round-robin.
module sub_bytes_scheduler #(
    parameter int NUM_COLS     = 4,
    parameter bit KEY_PRIORITY = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    sub_bytes_scheduler_if.slave    bus
);
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        S_RUN = 2'd1,
        K_RUN = 2'd2
    } state_t;

    state_t                     state_q;
    logic [CW-1:0]              col_cnt_q;
    logic [CW-1:0]              col_cnt_d;
    logic                       rr_k_q;
    logic [NUM_COLS-1:0][31:0]  st_cap_q;
    logic [NUM_COLS-1:0][31:0]  st_res_q;
    logic [31:0]                key_cap_q;
    logic [31:0]                key_res_q;
    logic                       st_ov_q;
    logic                       key_ov_q;

    logic idle;
    logic grant_k;
    logic st_fire;
    logic key_fire;
    logic col_last;

    // Readys depend only on the current requests so a requester sees its grant in the same cycle.
    always_comb begin
        idle          = (state_q == IDLE);
        grant_k       = KEY_PRIORITY | rr_k_q;
        bus.key_ready = idle & (~bus.st_valid | grant_k);
        bus.st_ready  = idle & (~bus.key_valid | ~grant_k);
        st_fire       = bus.st_valid & bus.st_ready;
        key_fire      = bus.key_valid & bus.key_ready;
        col_last      = (col_cnt_q == CW'(NUM_COLS - 1));
        col_cnt_d     = col_cnt_q + 1'b1;
        bus.sb_in     = 32'h0;
        case (state_q)
            S_RUN:   bus.sb_in = st_cap_q[col_cnt_q];
            K_RUN:   bus.sb_in = key_cap_q;
            default: bus.sb_in = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            rr_k_q    <= 1'b0;
            st_cap_q  <= '0;
            st_res_q  <= '0;
            key_cap_q <= 32'h0;
            key_res_q <= 32'h0;
            st_ov_q   <= 1'b0;
            key_ov_q  <= 1'b0;
        end else begin
            st_ov_q  <= 1'b0;
            key_ov_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (st_fire) begin
                        st_cap_q  <= bus.st_data;
                        col_cnt_q <= '0;
                        rr_k_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end else if (key_fire) begin
                        key_cap_q <= bus.key_word;
                        rr_k_q    <= 1'b0;
                        state_q   <= K_RUN;
                    end
                end
                S_RUN: begin
                    st_res_q[col_cnt_q] <= bus.sb_out;
                    if (col_last) begin
                        col_cnt_q <= '0;
                        st_ov_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        col_cnt_q <= col_cnt_d;
                    end
                end
                K_RUN: begin
                    key_res_q <= bus.sb_out;
                    key_ov_q  <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.st_out_valid  = st_ov_q;
    assign bus.st_out_data   = st_res_q;
    assign bus.key_out_valid = key_ov_q;
    assign bus.key_out_word  = key_res_q;
endmodule
